// File: rtl/sum_accumulator.sv
// Accumulates COUNT unsigned sums from the adder into a saturating total and
// presents each completed total, with a sticky saturation flag, on a valid/ready port.
module sum_accumulator #(
    parameter int WIDTH     = 4,
    parameter int ACC_WIDTH = 8,
    parameter int COUNT     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 clear,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_data,
    output logic                 out_sat
);

    localparam int                   CW       = $clog2(COUNT + 1);
    localparam logic [CW-1:0]        CNT_LAST = CW'(COUNT - 1);
    localparam logic [CW-1:0]        CNT_ONE  = CW'(1);
    localparam logic [ACC_WIDTH-1:0] ACC_MAX  = {ACC_WIDTH{1'b1}};
    localparam logic [ACC_WIDTH-1:0] ACC_ZERO = {ACC_WIDTH{1'b0}};
    localparam logic [CW-1:0]        CNT_ZERO = {CW{1'b0}};

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 sat_q, sat_d;
    logic [ACC_WIDTH-1:0] out_data_q, out_data_d;
    logic                 out_sat_q, out_sat_d;

    logic                 accept_s;
    logic [ACC_WIDTH:0]   sum_s;
    logic [ACC_WIDTH-1:0] acc_next_s;
    logic                 sat_next_s;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_ACCUM;
            acc_q      <= ACC_ZERO;
            cnt_q      <= CNT_ZERO;
            sat_q      <= 1'b0;
            out_data_q <= ACC_ZERO;
            out_sat_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            sat_q      <= sat_d;
            out_data_q <= out_data_d;
            out_sat_q  <= out_sat_d;
        end
    end

    // Saturating add: the extra top bit is the overflow detector
    always_comb begin
        accept_s   = in_valid && (state_q == ST_ACCUM) && !clear;
        sum_s      = {1'b0, acc_q} + {{(ACC_WIDTH + 1 - WIDTH){1'b0}}, in_data};
        acc_next_s = sum_s[ACC_WIDTH-1:0];
        sat_next_s = sat_q;
        if (sum_s[ACC_WIDTH]) begin
            acc_next_s = ACC_MAX;
            sat_next_s = 1'b1;
        end else begin
            acc_next_s = sum_s[ACC_WIDTH-1:0];
            sat_next_s = sat_q;
        end
    end

    // Next-state and register update logic
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        sat_d      = sat_q;
        out_data_d = out_data_q;
        out_sat_d  = out_sat_q;
        case (state_q)
            ST_ACCUM: begin
                if (clear) begin
                    acc_d = ACC_ZERO;
                    cnt_d = CNT_ZERO;
                    sat_d = 1'b0;
                end else if (accept_s) begin
                    acc_d = acc_next_s;
                    cnt_d = cnt_q + CNT_ONE;
                    sat_d = sat_next_s;
                    if (cnt_q == CNT_LAST) begin
                        state_d    = ST_HOLD;
                        out_data_d = acc_next_s;
                        out_sat_d  = sat_next_s;
                    end else begin
                        state_d = ST_ACCUM;
                    end
                end else begin
                    state_d = ST_ACCUM;
                end
            end
            ST_HOLD: begin
                // Handoff or abort both restart a fresh total; no accept this cycle
                if (clear || out_ready) begin
                    state_d = ST_ACCUM;
                    acc_d   = ACC_ZERO;
                    cnt_d   = CNT_ZERO;
                    sat_d   = 1'b0;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_ACCUM;
                acc_d   = ACC_ZERO;
                cnt_d   = CNT_ZERO;
                sat_d   = 1'b0;
            end
        endcase
    end

    // Outputs decoded from state and the output registers only
    always_comb begin
        out_data = out_data_q;
        out_sat  = out_sat_q;
        case (state_q)
            ST_ACCUM: begin
                in_ready  = 1'b1;
                out_valid = 1'b0;
            end
            ST_HOLD: begin
                in_ready  = 1'b0;
                out_valid = 1'b1;
            end
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed bench for sum_accumulator: an 8-bit default instance and a 5-bit
// instance for saturation, each checked every cycle against a plain-arithmetic model.
module tb_sum_accumulator;

    localparam int N = 4;

    logic       clk;
    logic       rst;
    logic       iv8, clr8, ordy8, irdy8, ov8, osat8;
    logic [3:0] d8;
    logic [7:0] od8;
    logic       iv5, clr5, ordy5, irdy5, ov5, osat5;
    logic [3:0] d5;
    logic [4:0] od5;

    int checks;
    int failures;
    bit chk_en;

    sum_accumulator #(.WIDTH(4), .ACC_WIDTH(8), .COUNT(N)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(irdy8), .in_data(d8),
        .clear(clr8), .out_valid(ov8), .out_ready(ordy8), .out_data(od8), .out_sat(osat8)
    );

    sum_accumulator #(.WIDTH(4), .ACC_WIDTH(5), .COUNT(N)) dut5 (
        .clk(clk), .rst(rst), .in_valid(iv5), .in_ready(irdy5), .in_data(d5),
        .clear(clr5), .out_valid(ov5), .out_ready(ordy5), .out_data(od5), .out_sat(osat5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: collects samples as a plain integer sum; the total is min(sum, max)
    // and saturation means the true sum exceeded max.
    typedef struct {
        bit hold;
        int sum;
        int cnt;
        int total;
        bit sat;
    } mdl_t;

    mdl_t m8, m5;

    function automatic mdl_t step(mdl_t m, bit r, bit c, bit v, int d, bit ordy, int mx);
        mdl_t n = m;
        if (r) begin
            n.hold = 0; n.sum = 0; n.cnt = 0; n.total = 0; n.sat = 0;
        end else if (c) begin
            n.hold = 0; n.sum = 0; n.cnt = 0;
        end else if (!m.hold) begin
            if (v) begin
                n.sum = m.sum + d;
                n.cnt = m.cnt + 1;
                if (n.cnt == N) begin
                    n.hold  = 1;
                    n.total = (n.sum > mx) ? mx : n.sum;
                    n.sat   = (n.sum > mx);
                    n.sum   = 0;
                    n.cnt   = 0;
                end
            end
        end else if (ordy) begin
            n.hold = 0;
        end
        return n;
    endfunction

    always @(posedge clk) begin
        m8 <= step(m8, rst, clr8, iv8, int'(d8), ordy8, 255);
        m5 <= step(m5, rst, clr5, iv5, int'(d5), ordy5, 31);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("m8_in_ready", 32'(irdy8), 32'(!m8.hold));
            chk("m8_out_valid", 32'(ov8), 32'(m8.hold));
            if (m8.hold) begin
                chk("m8_out_data", 32'(od8), 32'(m8.total));
                chk("m8_out_sat", 32'(osat8), 32'(m8.sat));
            end
            chk("m5_in_ready", 32'(irdy5), 32'(!m5.hold));
            chk("m5_out_valid", 32'(ov5), 32'(m5.hold));
            if (m5.hold) begin
                chk("m5_out_data", 32'(od5), 32'(m5.total));
                chk("m5_out_sat", 32'(osat5), 32'(m5.sat));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic feed8(input int v, input bit valid);
        iv8 = valid;
        d8  = v[3:0];
        cyc();
    endtask

    task automatic feed5(input int v, input bit valid);
        iv5 = valid;
        d5  = v[3:0];
        cyc();
    endtask

    // Pins the held total literally, then lets one handoff cycle pass
    task automatic total8(input string name, input int exp_d, input bit exp_s);
        iv8 = 1'b0;
        chk({name, "_valid"}, 32'(ov8), 32'd1);
        chk({name, "_data"}, 32'(od8), 32'(exp_d));
        chk({name, "_sat"}, 32'(osat8), 32'(exp_s));
        ordy8 = 1'b1;
        cyc();
        chk({name, "_ready_after"}, 32'(irdy8), 32'd1);
    endtask

    task automatic total5(input string name, input int exp_d, input bit exp_s);
        iv5 = 1'b0;
        chk({name, "_valid"}, 32'(ov5), 32'd1);
        chk({name, "_data"}, 32'(od5), 32'(exp_d));
        chk({name, "_sat"}, 32'(osat5), 32'(exp_s));
        ordy5 = 1'b1;
        cyc();
        chk({name, "_ready_after"}, 32'(irdy5), 32'd1);
    endtask

    task automatic chk_reset8(input string name);
        chk({name, "_in_ready"}, 32'(irdy8), 32'd1);
        chk({name, "_out_valid"}, 32'(ov8), 32'd0);
        chk({name, "_out_data"}, 32'(od8), 32'd0);
        chk({name, "_out_sat"}, 32'(osat8), 32'd0);
    endtask

    initial begin
        checks = 0; failures = 0; chk_en = 0;
        rst = 1'b1;
        iv8 = 0; d8 = 0; clr8 = 0; ordy8 = 1;
        iv5 = 0; d5 = 0; clr5 = 0; ordy5 = 1;
        cyc();
        cyc();
        chk_reset8("reset");
        chk("reset5_out_valid", 32'(ov5), 32'd0);
        chk("reset5_in_ready", 32'(irdy5), 32'd1);
        chk_en = 1;
        rst = 1'b0;

        // basic: 3+1+5+8 = 0x11
        feed8(3, 1); feed8(1, 1); feed8(5, 1); feed8(8, 1);
        total8("basic", 8'h11, 1'b0);

        // bubbles: invalid beats carry junk that must not count
        feed8(2, 1); feed8(9, 0); feed8(9, 0); feed8(4, 1); feed8(9, 0);
        feed8(6, 1); feed8(1, 1);
        total8("bubbles", 13, 1'b0);

        // backpressure: held for 5 cycles with in_valid pushing into HOLD
        ordy8 = 1'b0;
        feed8(15, 1); feed8(15, 1); feed8(15, 1); feed8(15, 1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(ov8), 32'd1);
            chk("bp_data", 32'(od8), 32'd60);
            chk("bp_in_ready", 32'(irdy8), 32'd0);
            if (i < 4) feed8(7, 1);
        end
        iv8 = 1'b0;
        ordy8 = 1'b1;
        cyc();
        chk("bp_handoff_valid", 32'(ov8), 32'd0);
        chk("bp_handoff_ready", 32'(irdy8), 32'd1);
        feed8(1, 1); feed8(1, 1); feed8(1, 1); feed8(1, 1);
        total8("after_bp", 4, 1'b0);

        // clear in ACCUM drops 7,7 and refuses the 9
        feed8(7, 1); feed8(7, 1);
        clr8 = 1'b1;
        feed8(9, 1);
        clr8 = 1'b0;
        feed8(1, 1); feed8(2, 1); feed8(3, 1); feed8(4, 1);
        total8("clear_accum", 10, 1'b0);

        // clear in HOLD: total is dropped and never transferred
        ordy8 = 1'b0;
        feed8(1, 1); feed8(1, 1); feed8(1, 1); feed8(1, 1);
        iv8 = 1'b0;
        chk("clr_hold_valid_before", 32'(ov8), 32'd1);
        clr8 = 1'b1;
        cyc();
        clr8 = 1'b0;
        ordy8 = 1'b1;
        chk("clr_hold_valid_drop", 32'(ov8), 32'd0);
        cyc();
        chk("clr_hold_no_transfer", 32'(ov8), 32'd0);

        // reset mid-ACCUM and mid-HOLD
        feed8(5, 1); feed8(5, 1);
        iv8 = 1'b0;
        rst = 1'b1;
        cyc();
        chk_reset8("rst_accum");
        rst = 1'b0;
        ordy8 = 1'b0;
        feed8(2, 1); feed8(2, 1); feed8(2, 1); feed8(2, 1);
        iv8 = 1'b0;
        chk("rst_hold_pending", 32'(od8), 32'd8);
        rst = 1'b1;
        cyc();
        chk_reset8("rst_hold");
        rst = 1'b0;
        ordy8 = 1'b1;
        feed8(1, 1); feed8(1, 1); feed8(1, 1); feed8(1, 1);
        total8("after_rst", 4, 1'b0);

        // saturation on the 5-bit instance: 15+15+15+1 clamps to 31
        feed5(15, 1); feed5(15, 1); feed5(15, 1); feed5(1, 1);
        total5("sat", 31, 1'b1);
        feed5(1, 1); feed5(1, 1); feed5(1, 1); feed5(1, 1);
        total5("sat_next", 4, 1'b0);

        cyc();
        chk_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
